// File: rtl/lcrc32_stream_gen.sv
// lcrc32_stream_gen: streaming LCRC-32 generator for the DL TX path, folding each TLP beat
// into a running CRC-32/ISO-HDLC (reflected 0xEDB88320, init all-ones) with no buffering.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start, seq_num  packet start and its 12-bit sequence number (taken in IDLE or DONE+crc_ready)
//   s_valid/s_ready beat handshake; s_data lane 0 is the first byte on the wire
//   s_keep, s_last  byte lane enables (honoured on the last beat only), final beat marker
//   crc_out         ~crc_reg, byte [7:0] transmitted first; crc_valid/crc_ready handshake
//   busy            packet in progress
//   err_len         sticky: TLP longer than MAX_BYTES
//   err_keep        sticky: partial keep on a non-last beat or non-contiguous keep on the last beat
module lcrc32_stream_gen #(
   parameter int DW         = 128,
   parameter int SEQ_PREFIX = 1,
   parameter int MAX_BYTES  = 4120
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [11:0]     seq_num,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [DW-1:0]   s_data,
   input  logic [DW/8-1:0] s_keep,
   input  logic            s_last,
   output logic [31:0]     crc_out,
   output logic            crc_valid,
   input  logic            crc_ready,
   output logic            busy,
   output logic            err_len,
   output logic            err_keep
);
   localparam int NB = DW / 8;
   localparam int CW = $clog2(MAX_BYTES + 2);

   typedef enum logic [1:0] {IDLE, DATA, DONE} state_t;

   state_t          state, state_nx;
   logic [31:0]     crc_reg, crc_nx, beat_crc, hdr_crc, start_crc, nbytes, sum;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [NB-1:0]   mask;
   logic            run, keep_bad, accept_start, err_len_nx, err_keep_nx;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign hdr_crc   = crc_byte(crc_byte(32'hFFFFFFFF, {4'h0, seq_num[11:8]}), seq_num[7:0]);
   assign start_crc = (SEQ_PREFIX != 0) ? hdr_crc : 32'hFFFFFFFF;

   // On the last beat only the lanes below the lowest cleared keep bit are folded;
   // any other beat folds every lane. A keep that differs from that mask is a violation.
   always_comb begin
      run      = 1'b1;
      mask     = '0;
      beat_crc = crc_reg;
      nbytes   = '0;
      for (int i = 0; i < NB; i++) begin
         run     = run & (s_keep[i] | ~s_last);
         mask[i] = run;
         if (run) begin
            beat_crc = crc_byte(beat_crc, s_data[8*i +: 8]);
            nbytes   = nbytes + 32'd1;
         end
      end
      keep_bad = (s_keep != mask);
      sum      = 32'(cnt) + nbytes;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         crc_reg  <= 32'hFFFFFFFF;
         cnt      <= '0;
         err_len  <= 1'b0;
         err_keep <= 1'b0;
      end else begin
         state    <= state_nx;
         crc_reg  <= crc_nx;
         cnt      <= cnt_nx;
         err_len  <= err_len_nx;
         err_keep <= err_keep_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      crc_nx       = crc_reg;
      cnt_nx       = cnt;
      err_len_nx   = err_len;
      err_keep_nx  = err_keep;
      s_ready      = (state == DATA);
      crc_valid    = (state == DONE);
      busy         = (state != IDLE);
      crc_out      = ~crc_reg;
      accept_start = start && (state == IDLE || (state == DONE && crc_ready));
      if (accept_start) begin
         state_nx    = DATA;
         crc_nx      = start_crc;
         cnt_nx      = '0;
         err_len_nx  = 1'b0;
         err_keep_nx = 1'b0;
      end else if (state == DONE && crc_ready) begin
         state_nx = IDLE;
      end else if (state == DATA && s_valid) begin
         crc_nx      = beat_crc;
         cnt_nx      = (sum > 32'(MAX_BYTES)) ? CW'(MAX_BYTES + 1) : sum[CW-1:0];
         err_len_nx  = err_len | (sum > 32'(MAX_BYTES));
         err_keep_nx = err_keep | keep_bad;
         state_nx    = s_last ? DONE : DATA;
      end
   end
endmodule

// File: tb/tb_lcrc32_stream_gen.sv
// tb_lcrc32_stream_gen: directed and randomized checks of lcrc32_stream_gen against a byte-queue CRC model.
module tb_lcrc32_stream_gen;
   logic         clk = 0, rst = 0, start = 0, s_valid = 0, s_last = 0, crc_ready = 0, sel = 0;
   logic [11:0]  seq = '0, cur_seq = '0;
   logic [127:0] data = '0;
   logic [15:0]  keep = '0;
   logic         a_ready, a_valid, a_busy, a_el, a_ek, b_ready, b_valid, b_busy, b_el, b_ek;
   logic [31:0]  a_crc, b_crc, exp_crc;
   logic [31:0]  crc_o;
   logic         rdy_o, vld_o, busy_o, el_o, ek_o;
   int           total = 0, bad = 0, nbeats = 0;
   logic [127:0] pd [8];
   logic [15:0]  pk [8];
   logic [7:0]   q [$];

   always #5 clk = ~clk;

   lcrc32_stream_gen #(.DW(32), .SEQ_PREFIX(0), .MAX_BYTES(4120)) u_a (
      .clk(clk), .rst(rst), .start(start & ~sel), .seq_num(seq),
      .s_valid(s_valid), .s_ready(a_ready), .s_data(data[31:0]), .s_keep(keep[3:0]), .s_last(s_last),
      .crc_out(a_crc), .crc_valid(a_valid), .crc_ready(crc_ready),
      .busy(a_busy), .err_len(a_el), .err_keep(a_ek));

   lcrc32_stream_gen #(.DW(128), .SEQ_PREFIX(1), .MAX_BYTES(32)) u_b (
      .clk(clk), .rst(rst), .start(start & sel), .seq_num(seq),
      .s_valid(s_valid), .s_ready(b_ready), .s_data(data), .s_keep(keep), .s_last(s_last),
      .crc_out(b_crc), .crc_valid(b_valid), .crc_ready(crc_ready),
      .busy(b_busy), .err_len(b_el), .err_keep(b_ek));

   assign crc_o  = sel ? b_crc   : a_crc;
   assign rdy_o  = sel ? b_ready : a_ready;
   assign vld_o  = sel ? b_valid : a_valid;
   assign busy_o = sel ? b_busy  : a_busy;
   assign el_o   = sel ? b_el    : a_el;
   assign ek_o   = sel ? b_ek    : a_ek;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_crc();
      logic [31:0] c = 32'hFFFFFFFF;
      foreach (q[j]) begin
         c ^= {24'h0, q[j]};
         repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   // Wire byte order: optional seq header, full non-last beats, then last-beat lanes up to the first cleared keep bit.
   task automatic model(output logic [31:0] ec, output logic eek, output logic eel);
      int nb = sel ? 16 : 4;
      int maxb = sel ? 32 : 4120;
      int tlp = 0;
      logic [15:0] kk;
      q.delete();
      eek = 1'b0;
      if (sel) begin
         q.push_back({4'h0, cur_seq[11:8]});
         q.push_back(cur_seq[7:0]);
      end
      for (int b = 0; b < nbeats; b++) begin
         kk = pk[b];
         if (b < nbeats - 1) begin
            if (kk != 16'((1 << nb) - 1)) eek = 1'b1;
            for (int l = 0; l < nb; l++) q.push_back(pd[b][8*l +: 8]);
            tlp += nb;
         end else begin
            if ((kk & (kk + 16'd1)) != 16'd0) eek = 1'b1;
            for (int l = 0; l < nb && kk[l]; l++) begin
               q.push_back(pd[b][8*l +: 8]);
               tlp++;
            end
         end
      end
      eel = (tlp > maxb);
      ec  = ref_crc();
   endtask

   task automatic gen(input int n);
      int nb = sel ? 16 : 4;
      nbeats = n;
      for (int b = 0; b < n; b++) begin
         pd[b] = {$urandom, $urandom, $urandom, $urandom};
         pk[b] = 16'((1 << nb) - 1);
      end
      pk[n-1] = 16'((1 << $urandom_range(0, nb)) - 1);
   endtask

   task automatic start_pkt(input logic [11:0] sq);
      start = 1; seq = sq; cur_seq = sq;
      @(posedge clk); #1;
      start = 0;
      chk1("enter_data_ready", rdy_o, 1'b1);
      chk1("enter_data_busy", busy_o, 1'b1);
      chk1("start_clears_err_keep", ek_o, 1'b0);
      chk1("start_clears_err_len", el_o, 1'b0);
   endtask

   task automatic feed(input bit gaps);
      logic eek, eel;
      for (int b = 0; b < nbeats; b++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 0;
            @(posedge clk); #1;
         end
         s_valid = 1; data = pd[b]; keep = pk[b]; s_last = (b == nbeats - 1);
         @(posedge clk); #1;
      end
      s_valid = 0; s_last = 0;
      model(exp_crc, eek, eel);
      chk1("crc_valid_latency", vld_o, 1'b1);
      chk32("crc_out", crc_o, exp_crc);
      chk1("err_keep", ek_o, eek);
      chk1("err_len", el_o, eel);
      chk1("done_s_ready", rdy_o, 1'b0);
   endtask

   task automatic finish(input int stall, input bit nxt, input logic [11:0] nsq);
      repeat (stall) begin
         @(posedge clk); #1;
         chk1("stall_valid", vld_o, 1'b1);
         chk32("stall_crc", crc_o, exp_crc);
         chk1("stall_s_ready", rdy_o, 1'b0);
      end
      crc_ready = 1; start = nxt; seq = nsq;
      if (nxt) cur_seq = nsq;
      @(posedge clk); #1;
      crc_ready = 0; start = 0;
      chk1("valid_drop", vld_o, 1'b0);
      chk1("after_done_ready", rdy_o, nxt);
      chk1("after_done_busy", busy_o, nxt);
   endtask

   initial begin
      #12;
      chk32("reset_a_crc", a_crc, 32'h0);
      chk32("reset_b_crc", b_crc, 32'h0);
      chk32("reset_a_flags", {27'h0, a_ready, a_valid, a_busy, a_el, a_ek}, 32'h0);
      chk32("reset_b_flags", {27'h0, b_ready, b_valid, b_busy, b_el, b_ek}, 32'h0);
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;

      sel = 0;
      nbeats = 3;
      pd[0] = 128'h34333231; pd[1] = 128'h38373635; pd[2] = 128'h39;
      pk[0] = 16'hF; pk[1] = 16'hF; pk[2] = 16'h1;
      start_pkt(12'h0); feed(0);
      chk32("check_123456789", crc_o, 32'hCBF43926);
      chk1("check_no_err", ek_o | el_o, 1'b0);
      finish(0, 0, 12'h0);

      nbeats = 1; pd[0] = 128'h61; pk[0] = 16'h1;
      start_pkt(12'h0); feed(0);
      chk32("single_a", crc_o, 32'hE8B7BE43);
      finish(0, 0, 12'h0);

      pk[0] = 16'h0;
      start_pkt(12'h0); feed(0);
      chk32("keep_zero", crc_o, 32'h0);
      chk1("keep_zero_legal", ek_o, 1'b0);
      finish(0, 0, 12'h0);

      for (int i = 0; i < 6; i++) begin
         gen($urandom_range(1, 6));
         start_pkt(12'($urandom)); feed(1);
         finish($urandom_range(0, 2), 0, 12'h0);
      end

      sel = 1;
      gen(4);
      start_pkt(12'h005); feed(0);
      chk1("four_beat_len_err", el_o, 1'b1);
      finish(5, 0, 12'h0);

      gen(2);
      start_pkt(12'hABC); feed(1);
      gen(1);
      finish(0, 1, 12'h123);
      feed(0);
      finish(0, 0, 12'h0);

      gen(2); pk[0] = 16'h00FF;
      start_pkt(12'h011); feed(0);
      chk1("nonlast_keep_err", ek_o, 1'b1);
      finish(0, 0, 12'h0);

      gen(1); pk[0] = 16'h000B;
      start_pkt(12'h022); feed(0);
      chk1("last_keep_err", ek_o, 1'b1);
      finish(0, 0, 12'h0);

      gen(2); pk[1] = 16'hFFFF;
      start_pkt(12'h033); feed(0);
      chk1("len_exact_max", el_o, 1'b0);
      finish(0, 0, 12'h0);

      gen(3); pk[2] = 16'h0001;
      start_pkt(12'h044); feed(0);
      chk1("len_max_plus_one", el_o, 1'b1);
      finish(0, 0, 12'h0);

      gen(3); pk[2] = 16'h0000;
      start_pkt(12'h055); feed(1);
      chk1("len_max_empty_last", el_o, 1'b0);
      finish(0, 0, 12'h0);

      gen(4); pk[0] = 16'h00FF;
      start_pkt(12'h007);
      s_valid = 1; data = pd[0]; keep = pk[0]; s_last = 0;
      @(posedge clk); #1;
      data = pd[1]; keep = pk[1];
      chk1("pre_reset_err_keep", ek_o, 1'b1);
      #2 rst = 0;
      #1;
      chk32("mid_reset_crc", crc_o, 32'h0);
      chk32("mid_reset_flags", {27'h0, rdy_o, vld_o, busy_o, el_o, ek_o}, 32'h0);
      s_valid = 0;
      @(posedge clk); #1;
      chk1("reset_held_no_valid", vld_o, 1'b0);
      rst = 1;
      @(posedge clk); #1;
      gen(2);
      start_pkt(12'h009); feed(1);
      finish(0, 0, 12'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
